// File: rtl/conv_pkg.sv
// Shared definitions for the 2-D convolution sequencer: default widths,
// the sequencer state encoding and the job legality rule.
package conv_pkg;

  localparam int DIM_W_DEF  = 10;
  localparam int DATA_W_DEF = 32;
  localparam int ACC_W_DEF  = 32;

  // IDLE is encoded as zero so a cleared state register reads as IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  // A job is runnable only if every dimension is non-zero and the filter
  // fits inside the input matrix in both directions.
  function automatic logic cfg_legal(input logic [31:0] ir,
                                     input logic [31:0] ic,
                                     input logic [31:0] fr,
                                     input logic [31:0] fc);
    return (ir != 0) && (ic != 0) && (fr != 0) && (fc != 0) &&
           (fr <= ir) && (fc <= ic);
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate for the convolution datapath.
// When en is high the accumulator loads the product (clr=1) or adds it to
// the running sum (clr=0). Product and sum wrap modulo 2^ACC_W.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0]    prod_full;
  logic signed [ACC_W-1:0] prod;

  // Both operands are sign-extended to the full product width so the
  // multiply is exact before it is fitted to the accumulator width.
  assign prod_full = $signed({{DATA_W{a[DATA_W-1]}}, a}) *
                     $signed({{DATA_W{b[DATA_W-1]}}, b});

  generate
    if (ACC_W <= PW) begin : g_trunc
      assign prod = prod_full[ACC_W-1:0];
    end else begin : g_sext
      assign prod = {{(ACC_W-PW){prod_full[PW-1]}}, prod_full};
    end
  endgenerate

  // Accumulator register: load on the first tap of an output, add otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? prod : acc + prod;
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Controller for a single 2-D convolution job. Latches the job dimensions on
// start, walks every valid output position and every filter tap, drives the
// memory read addresses and the accumulator, and presents each result on a
// valid/ready write port before pulsing done.
//
// Optional build macro CONV_RELU_EN: when defined, negative results are
// clamped to zero on out_data; timing is identical either way.
//
// Write port handshake: a result transfers on every rising clock edge where
// out_valid and out_ready are both high. Once out_valid rises, out_valid,
// out_row, out_col and out_data hold steady until that transfer; out_valid
// never drops without a transfer (only reset can cancel it).
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DIM_W-1:0]         in_rows,
  input  logic [DIM_W-1:0]         in_cols,
  input  logic [DIM_W-1:0]         flt_rows,
  input  logic [DIM_W-1:0]         flt_cols,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     rd_en,
  output logic [DIM_W-1:0]         in_row,
  output logic [DIM_W-1:0]         in_col,
  output logic [DIM_W-1:0]         flt_row,
  output logic [DIM_W-1:0]         flt_col,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] flt_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIM_W-1:0]         out_row,
  output logic [DIM_W-1:0]         out_col,
  output logic [ACC_W-1:0]         out_data,
  output state_t                   fsm_state
);

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  state_t state;

  // Job configuration captured on start; the live inputs are ignored after.
  logic [DIM_W-1:0] rows_q;
  logic [DIM_W-1:0] cols_q;
  logic [DIM_W-1:0] frows_q;
  logic [DIM_W-1:0] fcols_q;

  // Tap counters (filter row/column) and output position counters.
  logic [DIM_W-1:0] fr;
  logic [DIM_W-1:0] fc;
  logic [DIM_W-1:0] out_r;
  logic [DIM_W-1:0] out_c;

  logic [DIM_W-1:0] fr_nxt;
  logic [DIM_W-1:0] fc_nxt;
  logic [DIM_W-1:0] or_nxt;
  logic [DIM_W-1:0] oc_nxt;
  logic             tap_last_r;
  logic             tap_last_c;
  logic             pos_last_r;
  logic             pos_last_c;
  logic             job_ok;

  // Read data returns one cycle after rd_en, so the accumulator controls
  // are the read strobe and first-tap flag delayed by one cycle.
  logic             tap_vld;
  logic             tap_first;

  logic signed [ACC_W-1:0] acc;

  assign fsm_state = state;
  assign out_row   = out_r;
  assign out_col   = out_c;

  assign job_ok = cfg_legal(32'(rows_q), 32'(cols_q), 32'(frows_q), 32'(fcols_q));

  // Filter column is the inner loop, filter row the outer loop.
  assign tap_last_c = (fc == fcols_q - ONE);
  assign tap_last_r = (fr == frows_q - ONE);
  assign fc_nxt     = tap_last_c ? '0 : fc + ONE;
  assign fr_nxt     = tap_last_c ? fr + ONE : fr;

  // Output positions advance column first, wrapping into the next row.
  assign pos_last_c = (out_c == cols_q - fcols_q);
  assign pos_last_r = (out_r == rows_q - frows_q);
  assign oc_nxt     = pos_last_c ? '0 : out_c + ONE;
  assign or_nxt     = pos_last_c ? out_r + ONE : out_r;

  // Sequencer FSM with all control and address outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_en     <= 1'b0;
      in_row    <= '0;
      in_col    <= '0;
      flt_row   <= '0;
      flt_col   <= '0;
      out_valid <= 1'b0;
      rows_q    <= '0;
      cols_q    <= '0;
      frows_q   <= '0;
      fcols_q   <= '0;
      fr        <= '0;
      fc        <= '0;
      out_r     <= '0;
      out_c     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rows_q  <= in_rows;
            cols_q  <= in_cols;
            frows_q <= flt_rows;
            fcols_q <= flt_cols;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= CHECK;
          end
        end

        CHECK: begin
          if (!job_ok) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            out_r   <= '0;
            out_c   <= '0;
            fr      <= '0;
            fc      <= '0;
            rd_en   <= 1'b1;
            in_row  <= '0;
            in_col  <= '0;
            flt_row <= '0;
            flt_col <= '0;
            state   <= FETCH;
          end
        end

        FETCH: begin
          if (tap_last_r && tap_last_c) begin
            rd_en   <= 1'b0;
            in_row  <= '0;
            in_col  <= '0;
            flt_row <= '0;
            flt_col <= '0;
            state   <= DRAIN;
          end else begin
            fr      <= fr_nxt;
            fc      <= fc_nxt;
            in_row  <= out_r + fr_nxt;
            in_col  <= out_c + fc_nxt;
            flt_row <= fr_nxt;
            flt_col <= fc_nxt;
          end
        end

        // The last product lands in the accumulator at the end of this cycle.
        DRAIN: begin
          out_valid <= 1'b1;
          state     <= WRITE;
        end

        WRITE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (pos_last_r && pos_last_c) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              out_r   <= or_nxt;
              out_c   <= oc_nxt;
              fr      <= '0;
              fc      <= '0;
              rd_en   <= 1'b1;
              in_row  <= or_nxt;
              in_col  <= oc_nxt;
              flt_row <= '0;
              flt_col <= '0;
              state   <= FETCH;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Delay the read strobe and the first-tap marker to line up with the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_vld   <= 1'b0;
      tap_first <= 1'b0;
    end else begin
      tap_vld   <= rd_en;
      tap_first <= rd_en && (flt_row == '0) && (flt_col == '0);
    end
  end

  conv_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .en  (tap_vld),
    .clr (tap_first),
    .a   (in_data),
    .b   (flt_data),
    .acc (acc)
  );

`ifdef CONV_RELU_EN
  assign out_data = acc[ACC_W-1] ? '0 : acc;
`else
  assign out_data = acc;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: table of whole jobs with hand-computed results,
// plus hand-written sequences for start-while-busy and reset mid-job.
module tb_conv_sequencer;
  import conv_pkg::*;

  localparam int DW = 10;
  localparam int XW = 32;
  localparam int AW = 32;
  localparam int SW = 2 * DW + AW;
  localparam logic signed [XW-1:0] POISON = 32'sh5A5A_5A5A;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [DW-1:0] in_rows = '0, in_cols = '0, flt_rows = '0, flt_cols = '0;
  logic busy, done, err, rd_en, out_valid;
  logic [DW-1:0] in_row, in_col, flt_row, flt_col, out_row, out_col;
  logic signed [XW-1:0] in_data = '0;
  logic signed [XW-1:0] flt_data = '0;
  logic out_ready = 1'b1;
  logic [AW-1:0] out_data;
  state_t fsm_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv_sequencer #(.DIM_W(DW), .DATA_W(XW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_rows(in_rows), .in_cols(in_cols), .flt_rows(flt_rows), .flt_cols(flt_cols),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en),
    .in_row(in_row), .in_col(in_col), .flt_row(flt_row), .flt_col(flt_col),
    .in_data(in_data), .flt_data(flt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_data(out_data),
    .fsm_state(fsm_state)
  );

  // ---------------- memory model (1-cycle read latency) ----------------
  logic signed [XW-1:0] in_mem  [4][4];
  logic signed [XW-1:0] flt_mem [4][4];

  always @(posedge clk) begin
    if (rd_en) begin
      in_data  <= (in_row < 4 && in_col < 4) ? in_mem[in_row[1:0]][in_col[1:0]] : POISON;
      flt_data <= (flt_row < 4 && flt_col < 4) ? flt_mem[flt_row[1:0]][flt_col[1:0]] : POISON;
    end else begin
      in_data  <= POISON;
      flt_data <= POISON;
    end
  end

  // ---------------- consumer driver (optional backpressure) ----------------
  logic bp_mode = 1'b0;
  int   hold_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!bp_mode) out_ready = 1'b1;
    else if (out_valid) begin
      if (hold_cnt < 5) begin out_ready = 1'b0; hold_cnt++; end
      else out_ready = 1'b1;
    end else begin
      hold_cnt = 0;
      out_ready = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  int rd_total = 0, done_total = 0, hold_viol = 0, got_n = 0;
  int done_abs = 0, rise_abs = 0;
  logic done_err_s = 1'b0, rise_err = 1'b0, busy_q = 1'b0, held_v = 1'b0;
  logic [SW-1:0] held_w = '0;
  logic [SW-1:0] got_mem [64];

  always @(negedge clk) begin
    if (rd_en) rd_total++;
    if (done) begin done_total++; done_abs = cyc; done_err_s = err; end
    if (busy && !busy_q) begin rise_abs = cyc; rise_err = err; end
    busy_q = busy;
    if (out_valid) begin
      if (held_v && ({out_row, out_col, out_data} !== held_w)) hold_viol++;
      held_w = {out_row, out_col, out_data};
      held_v = !out_ready;
      if (out_ready) begin
        got_mem[got_n % 64] = {out_row, out_col, out_data};
        got_n++;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // ---------------- scoreboard / checking ----------------
  int checks = 0, errors = 0;
  logic [SW-1:0] exp_q[$];
  int rd_base, done_base, got_base, hold_base, start_abs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int ir, ic, fr, fc;
    int set;
    logic bp;
    int n_out, exp_done, exp_rd;
    logic exp_err;
    logic [AW-1:0] v [4];
  } vec_t;
  vec_t vecs [6];

  task automatic add_vec(input int i, input int ir, input int ic, input int fr, input int fc,
                         input int set, input logic bp, input int n, input int dn,
                         input int rd, input logic e,
                         input logic [AW-1:0] v0, input logic [AW-1:0] v1,
                         input logic [AW-1:0] v2, input logic [AW-1:0] v3);
    vecs[i].ir = ir; vecs[i].ic = ic; vecs[i].fr = fr; vecs[i].fc = fc;
    vecs[i].set = set; vecs[i].bp = bp; vecs[i].n_out = n;
    vecs[i].exp_done = dn; vecs[i].exp_rd = rd; vecs[i].exp_err = e;
    vecs[i].v[0] = v0; vecs[i].v[1] = v1; vecs[i].v[2] = v2; vecs[i].v[3] = v3;
  endtask

  task automatic load_set(input int set);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        in_mem[r][c] = '0;
        flt_mem[r][c] = '0;
      end
    case (set)
      0: begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) in_mem[r][c] = XW'(r * 4 + c + 1);
        flt_mem[0][0] = 1; flt_mem[0][2] = 1; flt_mem[1][1] = 1;
        flt_mem[2][0] = 1; flt_mem[2][2] = 1;
      end
      1: begin
        in_mem[0][0] = 3; in_mem[0][1] = -1; in_mem[1][0] = 0; in_mem[1][1] = 4;
        flt_mem[0][0] = -2;
      end
      default: begin
        in_mem[0][0] = 32'sh7FFF_FFFF;
        flt_mem[0][0] = 2;
      end
    endcase
  endtask

  // Called at posedge+1; leaves at posedge+1 of the cycle after start.
  task automatic start_job(input int i);
    int oc;
    load_set(vecs[i].set);
    bp_mode = vecs[i].bp;
    exp_q.delete();
    oc = vecs[i].ic - vecs[i].fc + 1;
    for (int k = 0; k < vecs[i].n_out; k++)
      exp_q.push_back({DW'(k / oc), DW'(k % oc), vecs[i].v[k]});
    rd_base = rd_total; done_base = done_total; got_base = got_n; hold_base = hold_viol;
    in_rows = DW'(vecs[i].ir); in_cols = DW'(vecs[i].ic);
    flt_rows = DW'(vecs[i].fr); flt_cols = DW'(vecs[i].fc);
    start = 1'b1;
    start_abs = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the live inputs: the job must run from the latched copy.
    in_rows = 1; in_cols = 1; flt_rows = 1; flt_cols = 1;
  endtask

  task automatic wait_job(input int i);
    int n;
    logic [SW-1:0] e;
    n = 0;
    while (done_total == done_base && n < 400) begin @(posedge clk); #1; n++; end
    chk($sformatf("job%0d_done_seen", i), 64'(done_total - done_base), 1);
    chk($sformatf("job%0d_done_cycle", i), 64'(done_abs - start_abs), 64'(vecs[i].exp_done));
    chk($sformatf("job%0d_done_err", i), done_err_s, vecs[i].exp_err);
    chk($sformatf("job%0d_rd_pulses", i), 64'(rd_total - rd_base), 64'(vecs[i].exp_rd));
    chk($sformatf("job%0d_busy_rise", i), 64'(rise_abs - start_abs), 1);
    chk($sformatf("job%0d_err_cleared", i), rise_err, 0);
    chk($sformatf("job%0d_write_count", i), 64'(got_n - got_base), 64'(vecs[i].n_out));
    for (int k = 0; k < vecs[i].n_out; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("job%0d_write%0d", i, k), got_mem[(got_base + k) % 64], e);
    end
    chk($sformatf("job%0d_hold_stable", i), 64'(hold_viol - hold_base), 0);
    chk($sformatf("job%0d_idle_busy", i), busy, 0);
    chk($sformatf("job%0d_idle_done", i), done, 0);
    chk($sformatf("job%0d_idle_err", i), err, vecs[i].exp_err);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    // Job table: dims, data set, backpressure, outputs, done cycle, rd pulses, err, results.
    add_vec(0, 4, 4, 3, 3, 0, 1'b0, 4, 46, 36, 1'b0, 30, 35, 50, 55);
    add_vec(1, 4, 4, 3, 3, 0, 1'b1, 4, 66, 36, 1'b0, 30, 35, 50, 55);
    add_vec(2, 4, 4, 5, 3, 0, 1'b0, 0, 2, 0, 1'b1, 0, 0, 0, 0);
`ifdef CONV_RELU_EN
    add_vec(3, 2, 2, 1, 1, 1, 1'b0, 4, 14, 4, 1'b0, 0, 2, 0, 0);
`else
    add_vec(3, 2, 2, 1, 1, 1, 1'b0, 4, 14, 4, 1'b0, -32'sd6, 2, 0, -32'sd8);
`endif
    add_vec(4, 4, 4, 0, 3, 0, 1'b0, 0, 2, 0, 1'b1, 0, 0, 0, 0);
`ifdef CONV_RELU_EN
    add_vec(5, 1, 1, 1, 1, 2, 1'b0, 1, 5, 1, 1'b0, 0, 0, 0, 0);
`else
    add_vec(5, 1, 1, 1, 1, 2, 1'b0, 1, 5, 1, 1'b0, 32'hFFFF_FFFE, 0, 0, 0);
`endif

    // Reset state.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {busy, done, err, rd_en, out_valid}, 0);
    chk("reset_addr", {in_row, in_col, flt_row, flt_col}, 0);
    chk("reset_out", {out_row, out_col, out_data}, 0);
    chk("reset_state", fsm_state, IDLE);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", {busy, rd_en, fsm_state}, {2'b00, IDLE});

    // Table-driven jobs.
    for (int i = 0; i < 6; i++) begin
      start_job(i);
      wait_job(i);
    end

    // Start asserted during FETCH must be ignored.
    start_job(0);
    n = 0;
    while (!rd_en && n < 50) begin @(posedge clk); #1; n++; end
    chk("busy_start_fetch", rd_en, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_job(0);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_start_no_restart", {busy, rd_en}, 0);

    // Reset during the second output's FETCH discards the job.
    start_job(0);
    n = 0;
    while (got_n == got_base && n < 100) begin @(posedge clk); #1; n++; end
    n = 0;
    while (!rd_en && n < 50) begin @(posedge clk); #1; n++; end
    chk("midrst_second_fetch", {rd_en, DW'(got_n - got_base)}, {1'b1, DW'(1)});
    rst = 1'b0;
    #1;
    chk("midrst_ctrl", {busy, done, err, rd_en, out_valid}, 0);
    chk("midrst_addr", {in_row, in_col, flt_row, flt_col}, 0);
    chk("midrst_out", {out_row, out_col, out_data}, 0);
    chk("midrst_state", fsm_state, IDLE);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_total - done_base), 0);
    chk("midrst_idle", {busy, fsm_state}, {1'b0, IDLE});

    // The block recovers cleanly after the aborted job.
    start_job(5);
    wait_job(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Controller that sequences the 2-D matrix convolution datapath for a single job.
- Latches job dimensions on start, then walks every valid output position and every filter tap.
- Per tap: issues read addresses to the input-matrix and filter memories and accumulates the products.
- Per output: presents the result on a valid/ready write port, then pulses done at job end.

Parameters:
- DIM_W, 10, width of every row/column index and dimension (max 1023).
- DATA_W, 32, signed element width of input and filter memories.
- ACC_W, 32, accumulator and result width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- in_rows, in_cols  in  DIM_W each  input matrix size.
- flt_rows, flt_cols  in  DIM_W each  filter size.
- busy  out  1  high from leaving IDLE until DONE ends.
- done  out  1  one-cycle pulse at job end.
- err  out  1  set with done when the config is illegal; cleared on the next start.
- rd_en  out  1  read strobe to both memories.
- in_row, in_col  out  DIM_W each  input memory address.
- flt_row, flt_col  out  DIM_W each  filter memory address.
- in_data  in  DATA_W  input element; valid exactly 1 cycle after rd_en.
- flt_data  in  DATA_W  filter element; valid exactly 1 cycle after rd_en.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_row, out_col  out  DIM_W each  output position.
- out_data  out  ACC_W  convolution result.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset is honoured in any state, including mid-job; a partial job is discarded and no done is issued.
- States:
  - IDLE: on start=1, latch config and clear err; go to CHECK. start in any other state is ignored.
  - CHECK (1 cycle): the job is illegal if any dimension is 0, flt_rows>in_rows or flt_cols>in_cols. Illegal -> DONE with err=1. Legal -> FETCH with out_r=out_c=0.
  - FETCH: one tap per cycle, rd_en=1, in_row=out_r+fr, in_col=out_c+fc, flt_row=fr, flt_col=fc. fc is the inner loop, fr the outer. After the last tap (fr=flt_rows-1, fc=flt_cols-1) go to DRAIN.
  - DRAIN (1 cycle): waits for the last product to accumulate; -> WRITE.
  - WRITE: out_valid=1; out_row/out_col/out_data are held stable until out_valid&&out_ready. On the handshake:
    - advance out_c (wrapping to 0 and incrementing out_r) and go to FETCH;
    - after the last position (in_rows-flt_rows, in_cols-flt_cols) go to DONE instead.
  - DONE (1 cycle): done=1; -> IDLE. busy drops in the same cycle done drops.
- Accumulator:
  - Cleared at the first tap of each output.
  - acc <= acc + signed(in_data)*signed(flt_data), registered in the cycle the data arrives.
  - Product and sum are truncated/wrapped modulo 2^ACC_W; no saturation.
- Per-output latency with out_ready held high: flt_rows*flt_cols + 2 cycles.
- Job latency: start sampled in cycle 0 -> CHECK in cycle 1 -> done in cycle 2 + N_out*(F+2), where N_out is the number of output positions and F = flt_rows*flt_cols.
- rd_en and the address outputs are 0 outside FETCH.

Optional Feature:
- CONV_RELU_EN defined: out_data = (acc<0) ? 0 : acc.
- Undefined: out_data = acc unmodified. Timing is identical either way.

Decomposition:
- Package conv_pkg holds the DIM_W/DATA_W/ACC_W defaults and the state enum (IDLE, CHECK, FETCH, DRAIN, WRITE, DONE).
- Sub-module conv_mac: signed multiply-accumulate with clear and enable inputs; the sequencer FSM and counters stay in conv_sequencer.

Test Plan:
- Basic job: 4x4 input of 1..16 row-major, 3x3 filter [1 0 1;0 1 0;1 0 1], out_ready=1 -> four writes: (0,0)=30, (0,1)=35, (1,0)=50, (1,1)=55; done in cycle 46; 36 rd_en pulses.
- Backpressure: same job with out_ready low for 5 cycles in each WRITE -> out_row/col/data held stable, results unchanged, done delayed by 20 cycles.
- Illegal config: flt_rows=5 with in_rows=4 -> no rd_en, done+err in cycle 2; a following legal start clears err.
- Edge sizes and sign:
  - 1x1 filter of value -2 on a 2x2 input [3 -1;0 4] -> outputs -6, 2, 0, -8;
  - with CONV_RELU_EN -> 0, 2, 0, 0.
- Start while busy: assert start during FETCH -> ignored, job completes normally. Then drop rst during the second FETCH -> all outputs 0 at once, state IDLE, no done.
- Wrap: DATA_W=ACC_W=32, 1x1 job with 0x7FFFFFFF*2 -> out_data=0xFFFFFFFE.
